tdm_demux4: RTL

- Receive end of the 4-lane time-division link: the transmit side uses 4:1 muxing to place one lane per beat on a shared WIDTH-bit bus.
- Block de-interleaves that stream back into four parallel lane words.
- Frames are 4 beats (slot 0..3) with a start-of-frame marker on slot 0. Complete frames are presented atomically on out1..out4 with a one-cycle out_valid pulse.
- Sits between the shared link bus and the per-lane consumers.

---
 rtl/tdm_demux4.sv | 92 +++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Receive side of the 4-lane TDM link: de-interleaves 4-beat frames from the shared bus
// and presents each complete frame atomically on out1..out4 with a one-cycle out_valid.
//
// state   | meaning
// HUNT    | not aligned, waiting for a beat with in_sof=1
// COLLECT | aligned, sel is the slot expected for the next accepted beat
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic             sync_err
);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] stage0;
    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            sel       <= 2'd0;
            stage0    <= '0;
            stage1    <= '0;
            stage2    <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sof) begin
                            stage0 <= in;
                            sel    <= 2'd1;
                            state  <= COLLECT;
                        end
                    end
                    default: begin
                        if (sel == 2'd0) begin
                            if (in_sof) begin
                                stage0 <= in;
                                sel    <= 2'd1;
                            end else begin
                                sync_err <= 1'b1;
                                sel      <= 2'd0;
                                state    <= HUNT;
                            end
                        end else if (in_sof) begin
                            // Premature SOF restarts the frame on this beat.
                            sync_err <= 1'b1;
                            stage0   <= in;
                            sel      <= 2'd1;
                        end else begin
                            case (sel)
                                2'd1: stage1 <= in;
                                2'd2: stage2 <= in;
                                default: begin
                                    out1      <= stage0;
                                    out2      <= stage1;
                                    out3      <= stage2;
                                    out4      <= in;
                                    out_valid <= 1'b1;
                                end
                            endcase
                            sel <= sel + 2'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
